mem_arbiter: RTL and testbench

- Shares the single multi-cycle main memory between three requesters: the instruction-cache miss path, the data-cache miss path, and the data-side write-through path.
- Sequences 8-word block fills with pipelined reads and returns fill words tagged for the requesting cache.
- Sits between both caches and main memory in the cached CPU, replacing direct inst_memory/data_memory access from the datapath.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 22 ++
 rtl/blk_word_cnt.sv | 38 +++
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter: state encoding, block geometry, owner tags.
package mem_arb_pkg;

    localparam int WORDS_PER_BLK = 8;
    localparam int BLK_OFF_BITS  = 4;
    // Read latency of the attached main memory, in cycles from issue to data valid.
    localparam int MEM_LAT       = 4;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WRITE      = 3'd1,
        S_FILL_ISSUE = 3'd2,
        S_FILL_DRAIN = 3'd3,
        S_DONE       = 3'd4
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Main-memory bus between the arbiter (master) and the multi-cycle memory (slave).
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_data_valid;

    modport master (
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_data_valid
    );

    modport slave (
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_data_valid
    );
endinterface

// File: rtl/blk_word_cnt.sv
// Word index counter within a cache block; terminal flags the increment of the last word.
module blk_word_cnt
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [2:0] cnt_o,
    output logic       term_o
);

    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_BLK - 1);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = inc_i && (cnt_q == LAST_WORD);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory among I-miss, D-miss and D write-through; sequences 8-word pipelined fills.
// Optional: define MEM_ARB_RR_EN to alternate between the two miss sides when both are pending.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss_req,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss_req,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    mem_arbiter_if.master     mem,
    output logic              fill_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              fill_to_d,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_ack,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << BLK_OFF_BITS) - 1);

    function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] addr);
        return addr & BLK_MASK;
    endfunction

    // Words are two bytes wide, so word k of a block sits at base + 2k.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [2:0]        idx);
        return base + ADDR_W'({idx, 1'b0});
    endfunction

    arb_state_e        state_q;
    logic              owner_q;
    logic [ADDR_W-1:0] base_q;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              d_wr_ack_q;
    logic              i_done_q;
    logic              d_done_q;
    logic              busy_q;
`ifdef MEM_ARB_RR_EN
    logic              last_miss_q;
`endif

    logic              gnt_wr;
    logic              gnt_fill;
    logic              owner_d;
    logic [ADDR_W-1:0] fill_base_d;
    logic [2:0]        issue_cnt;
    logic              issue_term;
    logic [2:0]        recv_cnt;
    logic              recv_term;
    logic              rx_active;

    always_comb begin
        gnt_wr   = 1'b0;
        gnt_fill = 1'b0;
        owner_d  = OWNER_I;
        if (state_q == S_IDLE) begin
            if (d_wr_req) begin
                gnt_wr = 1'b1;
            end else if (d_miss_req || i_miss_req) begin
                gnt_fill = 1'b1;
`ifdef MEM_ARB_RR_EN
                if (d_miss_req && i_miss_req) begin
                    owner_d = (last_miss_q == OWNER_D) ? OWNER_I : OWNER_D;
                end else begin
                    owner_d = d_miss_req ? OWNER_D : OWNER_I;
                end
`else
                owner_d = d_miss_req ? OWNER_D : OWNER_I;
`endif
            end
        end
        fill_base_d = (owner_d == OWNER_D) ? blk_base(d_miss_addr) : blk_base(i_miss_addr);
    end

    // Returns are accepted only while a fill is in flight; stray valids elsewhere are dropped.
    assign rx_active  = (state_q == S_FILL_ISSUE) || (state_q == S_FILL_DRAIN);
    assign fill_valid = rx_active && mem.mem_data_valid;
    assign fill_data  = fill_valid ? mem.mem_rdata : '0;
    assign fill_word  = recv_cnt;
    assign fill_to_d  = owner_q;

    blk_word_cnt u_issue_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (gnt_fill),
        .inc_i  (state_q == S_FILL_ISSUE),
        .cnt_o  (issue_cnt),
        .term_o (issue_term)
    );

    blk_word_cnt u_recv_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (gnt_fill),
        .inc_i  (fill_valid),
        .cnt_o  (recv_cnt),
        .term_o (recv_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWNER_I;
            base_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            d_wr_ack_q  <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_miss_q <= OWNER_D;
`endif
        end else begin
            d_wr_ack_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_wr) begin
                        state_q     <= S_WRITE;
                        mem_en_q    <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= d_wr_addr;
                        mem_wdata_q <= d_wr_data;
                        d_wr_ack_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (gnt_fill) begin
                        state_q    <= S_FILL_ISSUE;
                        owner_q    <= owner_d;
                        base_q     <= fill_base_d;
                        mem_en_q   <= 1'b1;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= fill_base_d;
                        busy_q     <= 1'b1;
`ifdef MEM_ARB_RR_EN
                        last_miss_q <= owner_d;
`endif
                    end
                end
                S_WRITE: begin
                    state_q  <= S_IDLE;
                    mem_en_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                S_FILL_ISSUE: begin
                    // Address register runs one word ahead of the issue counter.
                    if (issue_term) begin
                        state_q  <= S_FILL_DRAIN;
                        mem_en_q <= 1'b0;
                    end else begin
                        mem_addr_q <= word_addr(base_q, issue_cnt + 3'd1);
                    end
                end
                S_FILL_DRAIN: begin
                    if (recv_term) begin
                        state_q  <= S_DONE;
                        i_done_q <= (owner_q == OWNER_I);
                        d_done_q <= (owner_q == OWNER_D);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    mem_en_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_en    = mem_en_q;
    assign mem.mem_wr    = mem_wr_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign d_wr_ack      = d_wr_ack_q;
    assign i_fill_done   = i_done_q;
    assign d_fill_done   = d_done_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory with in-order returns and random stalls, request-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss_req = 1'b0;
    logic [15:0] i_miss_addr = '0;
    logic        d_miss_req = 1'b0;
    logic [15:0] d_miss_addr = '0;
    logic        d_wr_req = 1'b0;
    logic [15:0] d_wr_addr = '0;
    logic [15:0] d_wr_data = '0;
    logic        fill_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_to_d;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        d_wr_ack;
    logic        busy;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_miss_req  (i_miss_req),
        .i_miss_addr (i_miss_addr),
        .d_miss_req  (d_miss_req),
        .d_miss_addr (d_miss_addr),
        .d_wr_req    (d_wr_req),
        .d_wr_addr   (d_wr_addr),
        .d_wr_data   (d_wr_data),
        .mem         (bus),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .fill_word   (fill_word),
        .fill_to_d   (fill_to_d),
        .i_fill_done (i_fill_done),
        .d_fill_done (d_fill_done),
        .d_wr_ack    (d_wr_ack),
        .busy        (busy)
    );

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int cyc    = 0;

    bit          stall_en = 1'b0;
    bit          spur     = 1'b0;
    logic        mv_valid = 1'b0;
    logic [15:0] mv_data  = '0;
    bit          model_last = 1'b1;

    assign bus.mem_data_valid = mv_valid & rst_n;
    assign bus.mem_rdata      = mv_data;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } rd_t;
    rd_t rq[$];
    int  last_due = 0;
    logic [15:0] mem_store [logic [15:0]];

    function automatic logic [15:0] memval(input logic [15:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return a ^ 16'h5A3C;
    endfunction

    // Memory: samples the bus just after each edge, returns reads in issue order after MEM_LAT (+ stalls).
    always begin
        @(posedge clk);
        #1;
        cyc++;
        mv_valid = 1'b0;
        if (!rst_n) begin
            rq.delete();
            last_due = 0;
        end else begin
            if (bus.mem_en && bus.mem_wr) mem_store[bus.mem_addr] = bus.mem_wdata;
            if (bus.mem_en && !bus.mem_wr) begin
                int d;
                d = cyc + MEM_LAT + (stall_en ? int'($urandom_range(0, 2)) : 0);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                rq.push_back('{addr: bus.mem_addr, due: d});
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mv_valid = 1'b1;
                mv_data  = memval(rq[0].addr);
                void'(rq.pop_front());
            end else if (spur) begin
                mv_valid = 1'b1;
                mv_data  = 16'($urandom);
                spur     = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_fill_valid"}, 32'(fill_valid), 0);
        chk({tag, "_fill_data"}, 32'(fill_data), 0);
        chk({tag, "_fill_word"}, 32'(fill_word), 0);
        chk({tag, "_fill_to_d"}, 32'(fill_to_d), 0);
        chk({tag, "_i_done"}, 32'(i_fill_done), 0);
        chk({tag, "_d_done"}, 32'(d_fill_done), 0);
        chk({tag, "_wr_ack"}, 32'(d_wr_ack), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_mem_en"}, 32'(bus.mem_en), 0);
        chk({tag, "_mem_wr"}, 32'(bus.mem_wr), 0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
    endtask

    // Raise the given requests together, let them complete, then compare against the request-level model.
    task automatic serve(input bit dw, input logic [15:0] wa, input logic [15:0] wd,
                         input bit dm, input logic [15:0] da,
                         input bit im, input logic [15:0] ia, input bit lat_chk);
        logic [15:0] fb [2];
        bit          fd [2];
        int          nf;
        bit          d_first;
        int          guard;
        int          wr_cyc[$], ack_cyc[$], iss_cyc[$], bt_cyc[$], bt_word[$], bt_to_d[$];
        int          dn_cyc[$], dn_side[$];
        logic [15:0] wr_addr[$], wr_data[$], iss_addr[$], bt_data[$];

        nf = 0;
        if (dm && im) begin
            d_first = RR ? (model_last == 1'b0) : 1'b1;
            fb[0] = d_first ? (da & 16'hFFF0) : (ia & 16'hFFF0);
            fd[0] = d_first;
            fb[1] = d_first ? (ia & 16'hFFF0) : (da & 16'hFFF0);
            fd[1] = !d_first;
            nf = 2;
        end else if (dm) begin
            fb[0] = da & 16'hFFF0; fd[0] = 1'b1; nf = 1;
        end else if (im) begin
            fb[0] = ia & 16'hFFF0; fd[0] = 1'b0; nf = 1;
        end
        if (nf > 0) model_last = fd[nf-1];

        d_wr_addr = wa; d_wr_data = wd; d_miss_addr = da; i_miss_addr = ia;
        d_wr_req = dw; d_miss_req = dm; i_miss_req = im;
        guard = 0;
        while ((d_wr_req || d_miss_req || i_miss_req) && guard < 600) begin
            @(negedge clk);
            guard++;
            if (bus.mem_en && bus.mem_wr) begin
                wr_cyc.push_back(cyc); wr_addr.push_back(bus.mem_addr); wr_data.push_back(bus.mem_wdata);
            end
            if (bus.mem_en && !bus.mem_wr) begin
                iss_cyc.push_back(cyc); iss_addr.push_back(bus.mem_addr);
            end
            if (fill_valid) begin
                bt_cyc.push_back(cyc); bt_word.push_back(int'(fill_word));
                bt_to_d.push_back(int'(fill_to_d)); bt_data.push_back(fill_data);
            end
            if (d_wr_ack) begin ack_cyc.push_back(cyc); d_wr_req = 1'b0; end
            if (i_fill_done) begin dn_cyc.push_back(cyc); dn_side.push_back(0); i_miss_req = 1'b0; end
            if (d_fill_done) begin dn_cyc.push_back(cyc); dn_side.push_back(1); d_miss_req = 1'b0; end
        end
        chk("serve_timeout", 32'(d_wr_req | d_miss_req | i_miss_req), 0);
        d_wr_req = 1'b0; d_miss_req = 1'b0; i_miss_req = 1'b0;
        @(negedge clk);
        chk("idle_after_serve", 32'(busy), 0);

        chk("wr_count", wr_cyc.size(), dw ? 1 : 0);
        chk("ack_count", ack_cyc.size(), dw ? 1 : 0);
        if (dw && wr_cyc.size() == 1 && ack_cyc.size() == 1) begin
            chk("wr_addr", 32'(wr_addr[0]), 32'(wa));
            chk("wr_data", 32'(wr_data[0]), 32'(wd));
            chk("wr_ack_cycle", ack_cyc[0], wr_cyc[0]);
            if (nf > 0 && iss_cyc.size() > 0) chk("wr_before_fill", 32'(wr_cyc[0] < iss_cyc[0]), 1);
        end
        chk("issue_count", iss_addr.size(), 8 * nf);
        chk("beat_count", bt_data.size(), 8 * nf);
        chk("done_count", dn_cyc.size(), nf);
        for (int k = 0; k < nf; k++) begin
            for (int j = 0; j < 8; j++) begin
                int idx;
                idx = k * 8 + j;
                if (idx < iss_addr.size()) begin
                    chk($sformatf("issue_addr[%0d]", idx), 32'(iss_addr[idx]), 32'(fb[k] + 16'(2 * j)));
                    chk($sformatf("issue_cycle[%0d]", idx), iss_cyc[idx] - iss_cyc[k*8], j);
                end
                if (idx < bt_data.size()) begin
                    chk($sformatf("fill_word[%0d]", idx), bt_word[idx], j);
                    chk($sformatf("fill_to_d[%0d]", idx), bt_to_d[idx], int'(fd[k]));
                    chk($sformatf("fill_data[%0d]", idx), 32'(bt_data[idx]), 32'(memval(fb[k] + 16'(2 * j))));
                end
            end
            if (k < dn_cyc.size()) begin
                chk($sformatf("done_side[%0d]", k), dn_side[k], int'(fd[k]));
                if (k * 8 + 7 < bt_cyc.size())
                    chk($sformatf("done_cycle[%0d]", k), dn_cyc[k], bt_cyc[k*8+7] + 1);
            end
        end
        if (lat_chk && dn_cyc.size() > 0 && iss_cyc.size() > 0)
            chk("done_latency", dn_cyc[0] - iss_cyc[0], 8 + MEM_LAT);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bit dw, dm, im;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // All three requesters at once: write first, then the misses in priority/alternation order.
        serve(1'b1, 16'h0040, 16'hBEEF, 1'b1, 16'h2000, 1'b1, 16'h0100, 1'b0);

        serve(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h1236, 1'b1);

        spur = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("spur_fill_valid", 32'(fill_valid), 0);
        chk("spur_fill_word", 32'(fill_word), 0);
        chk("spur_busy", 32'(busy), 0);
        serve(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0488, 1'b0);

        stall_en = 1'b1;
        serve(1'b0, 16'h0000, 16'h0000, 1'b1, 16'h3456, 1'b0, 16'h0000, 1'b0);
        stall_en = 1'b0;

        // Abort a fill with reset partway through its issue phase.
        i_miss_addr = 16'h0800;
        i_miss_req  = 1'b1;
        guard = 0;
        while (!bus.mem_en && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_fill_started", 32'(bus.mem_en), 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        i_miss_req = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        model_last = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        serve(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0020, 1'b1);

        for (int it = 0; it < 24; it++) begin
            dw = 1'($urandom_range(0, 1));
            dm = 1'($urandom_range(0, 1));
            im = 1'($urandom_range(0, 1));
            if (!(dw || dm || im)) im = 1'b1;
            stall_en = 1'($urandom_range(0, 1));
            serve(dw, 16'($urandom), 16'($urandom), dm, 16'($urandom), im, 16'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        stall_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
